feature_frame_writer: RTL and testbench

//  Write side of the conv input FIFO (feature_fwft). Takes a raw 8-bit host pixel stream under

---
 rtl/conv_study_pkg.sv | 21 ++
 rtl/feature_pos_counter.sv | 40 ++++
 rtl/feature_frame_writer.sv | 99 +++++++++
 tb/tb_feature_frame_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_study_pkg.sv
// rtl/conv_study_pkg.sv - shared pixel type, image geometry defaults and writer state enum
package conv_study_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int IMG_ROWS   = 28;
    localparam int IMG_COLS   = 28;
    localparam int PAD        = 2;

    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } wr_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_pos_counter.sv
// rtl/feature_pos_counter.sv - row-major output position counter with wrap and last-position flag
module feature_pos_counter
    import conv_study_pkg::*;
#(
    parameter int NUM_ROWS = 32,
    parameter int NUM_COLS = 32,
    parameter int RW       = cnt_width(NUM_ROWS),
    parameter int CW       = cnt_width(NUM_COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic row_end;
    logic col_end;

    assign row_end = (row == RW'(NUM_ROWS - 1));
    assign col_end = (col == CW'(NUM_COLS - 1));
    assign last    = row_end && col_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/feature_frame_writer.sv
// rtl/feature_frame_writer.sv - frames host pixels into the conv input FIFO; FEATURE_ZERO_PAD_EN adds a zero border
module feature_frame_writer
    import conv_study_pkg::*;
#(
    parameter int DATA_WIDTH = conv_study_pkg::DATA_WIDTH,
    parameter int IMG_ROWS   = conv_study_pkg::IMG_ROWS,
    parameter int IMG_COLS   = conv_study_pkg::IMG_COLS,
    parameter int PAD        = conv_study_pkg::PAD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_pixel_valid,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    output logic                  o_pixel_ready,
    input  logic                  i_fifo_afull,
    output logic                  o_wr_en,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_frame_done
);

`ifdef FEATURE_ZERO_PAD_EN
    localparam int OUT_ROWS = IMG_ROWS + 2 * PAD;
    localparam int OUT_COLS = IMG_COLS + 2 * PAD;
`else
    localparam int OUT_ROWS = IMG_ROWS;
    localparam int OUT_COLS = IMG_COLS;
`endif
    localparam int RW = cnt_width(OUT_ROWS);
    localparam int CW = cnt_width(OUT_COLS);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_STREAM = 2'(STREAM);
    localparam logic [1:0] S_DONE   = 2'(DONE);

    logic [1:0]    state;
    logic          last_pending;
    logic [RW-1:0] pos_row;
    logic [CW-1:0] pos_col;
    logic          pos_last;
    logic          host_pos;
    logic          in_stream;
    logic          advance;

    feature_pos_counter #(
        .NUM_ROWS (OUT_ROWS),
        .NUM_COLS (OUT_COLS),
        .RW       (RW),
        .CW       (CW)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_IDLE),
        .en   (advance),
        .row  (pos_row),
        .col  (pos_col),
        .last (pos_last)
    );

`ifdef FEATURE_ZERO_PAD_EN
    assign host_pos = (pos_row >= RW'(PAD)) && (pos_row < RW'(PAD + IMG_ROWS)) &&
                      (pos_col >= CW'(PAD)) && (pos_col < CW'(PAD + IMG_COLS));
`else
    logic unused_pos;
    assign unused_pos = ^{pos_row, pos_col};
    assign host_pos   = 1'b1;
`endif

    // The last write is in flight while last_pending is set; nothing more may be accepted.
    assign in_stream     = (state == S_STREAM) && !last_pending;
    assign o_pixel_ready = in_stream && !i_fifo_afull && host_pos;
    assign advance       = in_stream && !i_fifo_afull && (!host_pos || i_pixel_valid);

    assign o_busy       = (state == S_STREAM);
    assign o_frame_done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            last_pending <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_data    <= '0;
        end else begin
            o_wr_en      <= advance;
            last_pending <= advance && pos_last;
            if (advance) begin
                o_wr_data <= host_pos ? i_pixel : '0;
            end
            case (state)
                S_IDLE:   if (i_start) state <= S_STREAM;
                S_STREAM: if (last_pending) state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_frame_writer.sv
// tb/tb_feature_frame_writer.sv - self-checking bench for feature_frame_writer, both FEATURE_ZERO_PAD_EN builds
module tb_feature_frame_writer;

`ifdef FEATURE_ZERO_PAD_EN
    localparam int PB = 2;
`else
    localparam int PB = 0;
`endif
    localparam int OR_T  = 28 + 2 * PB;
    localparam int OC_T  = 28 + 2 * PB;
    localparam int FRAME = OR_T * OC_T;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_pixel_valid;
    logic [7:0] i_pixel;
    logic       o_pixel_ready;
    logic       i_fifo_afull;
    logic       o_wr_en;
    logic [7:0] o_wr_data;
    logic       o_busy;
    logic       o_frame_done;

    always #5 clk = ~clk;

    feature_frame_writer dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_pixel_valid (i_pixel_valid),
        .i_pixel       (i_pixel),
        .o_pixel_ready (o_pixel_ready),
        .i_fifo_afull  (i_fifo_afull),
        .o_wr_en       (o_wr_en),
        .o_wr_data     (o_wr_data),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit is_host(input int p);
        int r;
        int c;
        r = p / OC_T;
        c = p % OC_T;
        return (r >= PB) && (r < PB + 28) && (c >= PB) && (c < PB + 28);
    endfunction

    // stimulus controls
    int mode_pix   = 0;
    int mode_valid = 0;
    int afull_mode = 0;
    int cyc        = 0;
    int host_idx   = 0;

    always @(negedge clk) begin
        cyc++;
        i_pixel = (mode_pix != 0) ? 8'hFF : 8'(host_idx);
        case (mode_valid)
            0:       i_pixel_valid = 1'b0;
            1:       i_pixel_valid = 1'b1;
            default: i_pixel_valid = 1'($urandom_range(0, 1));
        endcase
        i_fifo_afull = (afull_mode != 0) ? 1'(((cyc / 3) % 2)) : 1'b0;
    end

    // model: phase 0 idle, 1 streaming, 2 last write visible, 3 done pulse
    int         m_phase   = 0;
    int         m_pos     = 0;
    logic       e_wr_en   = 1'b0;
    logic [7:0] e_wr_data = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_phase   = 0;
            m_pos     = 0;
            e_wr_en   = 1'b0;
            e_wr_data = 8'h00;
        end else begin
            e_wr_en = 1'b0;
            case (m_phase)
                0: if (i_start) begin m_phase = 1; m_pos = 0; end
                1: if (!i_fifo_afull && (!is_host(m_pos) || i_pixel_valid)) begin
                    e_wr_en = 1'b1;
                    if (is_host(m_pos)) begin
                        e_wr_data = i_pixel;
                        host_idx++;
                    end else begin
                        e_wr_data = 8'h00;
                    end
                    if (m_pos == FRAME - 1) m_phase = 2;
                    else m_pos++;
                end
                2: m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    logic [7:0] got[$];
    int done_cnt    = 0;
    int done_cyc    = 0;
    int last_wr_cyc = 0;

    always @(negedge clk) begin
        #2;
        check("wr_en", o_wr_en, e_wr_en);
        check("wr_data", o_wr_data, e_wr_data);
        check("busy", o_busy, (m_phase == 1) || (m_phase == 2));
        check("frame_done", o_frame_done, m_phase == 3);
        check("pixel_ready", o_pixel_ready,
              (m_phase == 1) && !i_fifo_afull && is_host(m_pos));
        if (o_wr_en === 1'b1) begin
            got.push_back(o_wr_data);
            last_wr_cyc = cyc;
        end
        if (o_frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int at(input int i);
        return (i < got.size()) ? int'(got[i]) : -1;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic start_frame();
        got.delete();
        host_idx = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_count"}, got.size(), FRAME);
        check({tag, "_done_lat"}, done_cyc - last_wr_cyc, 1);
    endtask

    initial begin
        int n;
        int d0;
        rst           = 1'b1;
        i_start       = 1'b0;
        i_pixel_valid = 1'b0;
        i_pixel       = 8'h00;
        i_fifo_afull  = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("reset_wr_en", o_wr_en, 0);
        check("reset_wr_data", o_wr_data, 0);
        check("reset_busy", o_busy, 0);
        check("reset_ready", o_pixel_ready, 0);
        check("reset_done", o_frame_done, 0);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-frame after 100 writes
        mode_valid = 1;
        start_frame();
        n = 0;
        while (got.size() < 100 && n < 3000) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("t1_reached_100", got.size() >= 100, 1);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("t1_wr_en", o_wr_en, 0);
        check("t1_wr_data", o_wr_data, 0);
        check("t1_busy", o_busy, 0);
        repeat (5) @(negedge clk);
        check("t1_no_done", done_cnt, d0);
        start_frame();
        wait_done("t1_fresh", 5000);
        frame_checks("t1_fresh");

        // back-to-back pixels with incrementing data
        start_frame();
        wait_done("t2", 5000);
        frame_checks("t2");
`ifdef FEATURE_ZERO_PAD_EN
        check("t2_first", at(0), 0);
        check("t2_host1", at(67), 1);
        check("t2_host27", at(93), 27);
        check("t2_rborder", at(94), 0);
        check("t2_last", at(FRAME - 1), 0);
`else
        check("t2_first", at(0), 0);
        check("t2_second", at(1), 1);
        check("t2_wrap", at(256), 0);
        check("t2_last", at(783), 15);
`endif

        // almost-full toggling every 3 cycles
        afull_mode = 1;
        start_frame();
        wait_done("t3", 8000);
        frame_checks("t3");
        afull_mode = 0;

        // constant FF pixels
        mode_pix = 1;
        start_frame();
        wait_done("t4", 5000);
        frame_checks("t4");
`ifdef FEATURE_ZERO_PAD_EN
        check("t4_pos65", at(65), 0);
        check("t4_pos66", at(66), 255);
        check("t4_row5_c1", at(161), 0);
        check("t4_row5_c2", at(162), 255);
        check("t4_row5_c29", at(189), 255);
        check("t4_row5_c30", at(190), 0);
        check("t4_pos957", at(957), 255);
        check("t4_pos958", at(958), 0);
`else
        check("t4_first", at(0), 255);
        check("t4_last", at(783), 255);
`endif
        mode_pix = 0;

        // stray starts during STREAM and DONE
        d0 = done_cnt;
        start_frame();
        repeat (50) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("t5", 5000);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        check("t5_one_frame", done_cnt - d0, 1);
        check("t5_idle_busy", o_busy, 0);
        check("t5_idle_ready", o_pixel_ready, 0);
        check("t5_count", got.size(), FRAME);

        // random host gaps
        mode_valid = 2;
        start_frame();
        wait_done("t6", 10000);
        frame_checks("t6");
        mode_valid = 0;

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
